gun_cursor_accum: RTL
=====================

Name: gun_cursor_accum

Overview:
- Parametrised multi-player lightgun/cursor position generator for Williams-2 class cores (Turkey Shoot and successors).
- Converts digital joystick directions, or an absolute analog stick, into saturating per-axis gun coordinates.
- Steps are paced by the game's slow tick (cnt_4ms). Digital mode adds immediate first step, hold-repeat divider, acceleration and recentre.
- Sits between the hps_io joystick decode and the williams2 gun_h/gun_v inputs. Runs on clk_sys.

Parameters:
- NCH, 2, number of player channels.
- PW, 6, position width per axis; POS_MAX = 2^PW-1.
- CENTER, 32, reset/recentre position (must be <= POS_MAX).
- DIV_MAX, 3, repeat divider terminal count; a held direction steps once every DIV_MAX+1 ticks.
- ACCEL_HOLD, 16, ticks of continuous hold before step size becomes 2.
- AW, 8, analog input width per axis (AW >= PW).

Ports:
- clk_sys  in  1  core system clock (12 MHz).
- reset_n  in  1  asynchronous active-low reset.
- tick  in  1  level rate tick from game; its rising edge is the step event.
- recenter  in  NCH  per-channel request to load CENTER on both axes.
- abs_mode  in  NCH  1 = analog absolute mode, 0 = digital relative mode.
- dir_left/dir_right/dir_up/dir_down  in  NCH each  per-channel digital directions, active-high.
- ana_x, ana_y  in  NCH*AW each  unsigned analog positions, channel c at [c*AW +: AW].
- pos_h, pos_v  out  NCH*PW each  gun coordinates, channel c at [c*PW +: PW].
- moved  out  NCH  one-cycle pulse when any axis of channel c changed value.

Behaviour:
- Reset: pos_h = pos_v = CENTER; moved = 0; all dividers, hold counters, prev-direction regs and tick_r = 0. Asynchronous assert, synchronous deassert is upstream.
- Tick edge: tick_r <= tick every cycle. ev = tick & ~tick_r. All step logic below is evaluated only on cycles where ev = 1. Single-cycle latency: pos updates on the cycle after the edge is seen in tick_r.
- Per axis, digital mode: neg = left/up, pos = right/down; act = neg XOR pos; both-pressed behaves as released.
  - Released (act = 0): div <= 0, hold <= 0, prev <= 0, position unchanged.
  - New press (act & ~prev): step immediately, div <= 0, hold <= 1, prev <= 1.
  - Held (act & prev): hold <= min(hold+1, ACCEL_HOLD), saturating.
    - If div == DIV_MAX: div <= 0 and step.
    - Otherwise div <= div+1, no step.
  - Step size = 2 if hold >= ACCEL_HOLD, else 1. Hold is compared before its increment.
  - Saturating arithmetic in PW+1 bits, clamped to [0, POS_MAX].
    - Example: pos 1, step -2 -> 0.
    - Example: pos 62, step +2 -> 63.
    - Never wraps.
- Analog mode: on ev, pos <= ana[AW-1 -: PW] (top PW bits); div, hold and prev are cleared. Switching abs_mode mid-hold takes effect on the next ev with no glitch step.
- Recenter: recenter[c] is sampled every cycle, independent of ev, and has priority over a coincident ev. pos <= CENTER; div, hold, prev <= 0. In analog mode the next ev overwrites the position.
- moved[c]: asserted the cycle after any pos_h/pos_v register of channel c takes a new, different value. Clamped no-op steps and recentre-to-same-value do not pulse.
- Channels are fully independent. Simultaneous events on all channels are processed in the same cycle.

Decomposition:
- Package gun_pkg holds:
  - typedef axis_state_t {div, hold, prev};
  - function sat_add(pos, step, dir) returning PW bits;
  - localparam POS_MAX.
- Sub-module gun_axis: one axis of one channel. Ports: clk_sys, reset_n, ev, recenter, abs_mode, neg, pos, ana, position, changed.
- Top instantiates 2*NCH gun_axis in a generate loop. The top owns tick edge detect and the moved OR.

Test Plan:
- Reset release, no input -> all pos_h/pos_v = 32, moved = 0; tick toggling alone changes nothing.
- Ch0 dir_right held from pos 32:
  - step on 1st edge -> 33;
  - next steps at edges 5, 9, 13 -> 34, 35, 36;
  - after 16 edges held, steps are +2.
  - Released then repressed -> immediate +1.
- Ch1 dir_left held long from pos 1 in accel -> 0, stays 0; moved pulses exactly once.
- dir_up and dir_down both held on ch0 -> pos_v unchanged, hold cleared. Releasing dir_down -> immediate -1 on next edge.
- abs_mode[0] = 1, ana_x = 0xC7 -> pos_h = 49 on next edge. recenter[0] on the same cycle as the edge -> pos_h = 32, then the following edge gives 49.
- Async reset_n low mid-hold at pos 40 -> immediately 32, div/hold cleared. After release, the first held edge is treated as a new press.

Source files
------------

// File: rtl/gun_pkg.sv
// Shared types and helpers for the lightgun cursor accumulator.
// PW here fixes the coordinate width used by every gun_axis instance.
package gun_pkg;

    localparam int unsigned PW = 6;
    localparam logic [PW-1:0] POS_MAX = '1;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [CW-1:0] div;
        logic [CW-1:0] hold;
        logic          prev;
    } axis_state_t;

    // dir = 1 moves toward POS_MAX; the result clamps instead of wrapping.
    function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] pos,
                                              input logic [1:0]    step,
                                              input logic          dir);
        logic [PW:0] sum;
        if (dir) begin
            sum = {1'b0, pos} + {{(PW-1){1'b0}}, step};
            return (sum > {1'b0, POS_MAX}) ? POS_MAX : sum[PW-1:0];
        end
        return ({1'b0, pos} < {{(PW-1){1'b0}}, step}) ? '0 : pos - {{(PW-2){1'b0}}, step};
    endfunction

endpackage

// File: rtl/gun_axis.sv
// One axis of one player: digital repeat/accelerate stepping, analog absolute load,
// and recentre.
module gun_axis
    import gun_pkg::*;
#(
    parameter int unsigned AW         = 8,
    parameter int unsigned CENTER     = 32,
    parameter int unsigned DIV_MAX    = 3,
    parameter int unsigned ACCEL_HOLD = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ev,
    input  logic          recenter,
    input  logic          abs_mode,
    input  logic          neg,
    input  logic          pos,
    input  logic [AW-1:0] ana,
    output logic [PW-1:0] position,
    output logic          changed
);

    localparam logic [PW-1:0] CenterPos = PW'(CENTER);
    localparam logic [CW-1:0] DivMax    = CW'(DIV_MAX);
    localparam logic [CW-1:0] HoldMax   = CW'(ACCEL_HOLD);

    axis_state_t   st_q, st_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          step;
    logic [1:0]    step_sz;

    logic unused_ana;
    assign unused_ana = ^ana[AW-PW-1:0];

    always_comb begin
        st_d    = st_q;
        pos_d   = pos_q;
        step    = 1'b0;
        step_sz = (st_q.hold >= HoldMax) ? 2'd2 : 2'd1;
        if (recenter) begin
            st_d  = '0;
            pos_d = CenterPos;
        end else if (ev) begin
            if (abs_mode) begin
                st_d  = '0;
                pos_d = ana[AW-1 -: PW];
            end else if (!(neg ^ pos)) begin
                st_d = '0;
            end else if (!st_q.prev) begin
                step      = 1'b1;
                st_d.div  = '0;
                st_d.hold = CW'(1);
                st_d.prev = 1'b1;
            end else begin
                if (st_q.hold < HoldMax) st_d.hold = st_q.hold + CW'(1);
                if (st_q.div == DivMax) begin
                    st_d.div = '0;
                    step     = 1'b1;
                end else begin
                    st_d.div = st_q.div + CW'(1);
                end
            end
        end
        // act implies exactly one of neg/pos, so pos alone gives the direction
        if (step) pos_d = sat_add(pos_q, step_sz, pos);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= '0;
            pos_q   <= CenterPos;
            changed <= 1'b0;
        end else begin
            st_q    <= st_d;
            pos_q   <= pos_d;
            changed <= (pos_d != pos_q);
        end
    end

    assign position = pos_q;

endmodule

// File: rtl/gun_cursor_accum.sv
// Multi-player gun cursor generator: tick edge detect, per-axis accumulators and
// per-channel movement pulse.
module gun_cursor_accum #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned PW         = gun_pkg::PW,
    parameter int unsigned CENTER     = 32,
    parameter int unsigned DIV_MAX    = 3,
    parameter int unsigned ACCEL_HOLD = 16,
    parameter int unsigned AW         = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              tick,
    input  logic [NCH-1:0]    recenter,
    input  logic [NCH-1:0]    abs_mode,
    input  logic [NCH-1:0]    dir_left,
    input  logic [NCH-1:0]    dir_right,
    input  logic [NCH-1:0]    dir_up,
    input  logic [NCH-1:0]    dir_down,
    input  logic [NCH*AW-1:0] ana_x,
    input  logic [NCH*AW-1:0] ana_y,
    output logic [NCH*PW-1:0] pos_h,
    output logic [NCH*PW-1:0] pos_v,
    output logic [NCH-1:0]    moved
);

    logic tick_r;
    logic ev;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) tick_r <= 1'b0;
        else          tick_r <= tick;
    end

    assign ev = tick & ~tick_r;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic h_chg, v_chg;

        gun_axis #(
            .AW        (AW),
            .CENTER    (CENTER),
            .DIV_MAX   (DIV_MAX),
            .ACCEL_HOLD(ACCEL_HOLD)
        ) u_h (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .ev      (ev),
            .recenter(recenter[c]),
            .abs_mode(abs_mode[c]),
            .neg     (dir_left[c]),
            .pos     (dir_right[c]),
            .ana     (ana_x[c*AW +: AW]),
            .position(pos_h[c*PW +: PW]),
            .changed (h_chg)
        );

        gun_axis #(
            .AW        (AW),
            .CENTER    (CENTER),
            .DIV_MAX   (DIV_MAX),
            .ACCEL_HOLD(ACCEL_HOLD)
        ) u_v (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .ev      (ev),
            .recenter(recenter[c]),
            .abs_mode(abs_mode[c]),
            .neg     (dir_up[c]),
            .pos     (dir_down[c]),
            .ana     (ana_y[c*AW +: AW]),
            .position(pos_v[c*PW +: PW]),
            .changed (v_chg)
        );

        assign moved[c] = h_chg | v_chg;
    end

endmodule
